// File: rtl/logic_unit_pipe_if.sv
// Bundle of the handshake and data signals of logic_unit_pipe.
//   master : upstream source and downstream consumer side (drives in_valid,
//            A, B, op, out_ready; observes everything else)
//   slave  : the pipeline itself
// Members:
//   in_valid/in_ready   input handshake
//   A, B [WIDTH]        operands
//   op [3]              function select
//   out_valid/out_ready output handshake
//   Y [WIDTH]           result
//   zero, parity, err   result flags
//   op_count [CNT_WIDTH] delivered-beat counter
interface logic_unit_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2:0]           op;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     Y;
  logic                 zero;
  logic                 parity;
  logic                 err;
  logic [CNT_WIDTH-1:0] op_count;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Y, zero, parity, err, op_count
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Y, zero, parity, err, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control.
// Applies AND/OR/NOT/XOR/NAND/NOR/XNOR (op 0..6) to WIDTH-bit operands;
// op 7 is illegal and yields Y=0 with err set. Each result carries zero
// and parity flags, and op_count counts delivered beats (wrapping).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of logic_unit_pipe_if (handshakes, operands,
//          result, flags, counter)
module logic_unit_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
    return y;
  endfunction

  function automatic logic zero_flag(input logic [WIDTH-1:0] y);
    return ~|y;
  endfunction

  function automatic logic parity_flag(input logic [WIDTH-1:0] y);
    return ^y;
  endfunction

  // Single advance enable for the whole pipe: both stages move together or
  // both hold. It depends only on registered state and out_ready, so there
  // is no path from in_valid to in_ready.
  logic adv;

  logic                 vld_p1_q;
  logic [WIDTH-1:0]     a_p1_q;
  logic [WIDTH-1:0]     b_p1_q;
  logic [2:0]           op_p1_q;

  logic                 vld_p2_q;
  logic [WIDTH-1:0]     y_p2_q;
  logic                 zero_p2_q;
  logic                 parity_p2_q;
  logic                 err_p2_q;

  logic [WIDTH-1:0]     y_p2_d;
  logic                 zero_p2_d;
  logic                 parity_p2_d;
  logic                 err_p2_d;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign adv          = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = adv;

  // ---- stage 1: capture operands ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= bus.in_valid;
    end
  end

  // Operand registers carry no reset: they are only consumed when vld_p1_q
  // is set, and that bit is cleared by reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p1_q  <= bus.A;
      b_p1_q  <= bus.B;
      op_p1_q <= bus.op;
    end
  end

  // ---- stage 2: evaluate gate and flags ----
  always_comb begin
    y_p2_d      = gate_fn(op_p1_q, a_p1_q, b_p1_q);
    zero_p2_d   = zero_flag(y_p2_d);
    parity_p2_d = parity_flag(y_p2_d);
    err_p2_d    = (op_p1_q == 3'd7);
  end

  // Result and flags update only when a real beat moves in, so they keep
  // their reset values until the first beat and never pick up bubble data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q    <= 1'b0;
      y_p2_q      <= '0;
      zero_p2_q   <= 1'b0;
      parity_p2_q <= 1'b0;
      err_p2_q    <= 1'b0;
    end else if (adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        y_p2_q      <= y_p2_d;
        zero_p2_q   <= zero_p2_d;
        parity_p2_q <= parity_p2_d;
        err_p2_q    <= err_p2_d;
      end
    end
  end

  // ---- output side: delivered-beat counter ----
  always_comb begin
    cnt_d = cnt_q;
    if (vld_p2_q && bus.out_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.Y         = y_p2_q;
  assign bus.zero      = zero_p2_q;
  assign bus.parity    = parity_p2_q;
  assign bus.err       = err_p2_q;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe. Three instances:
// u8 (WIDTH=8), u1 (WIDTH=1) and u3 (WIDTH=8, CNT_WIDTH=3).
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_WIDTH(16)) b8 ();
  logic_unit_pipe_if #(.WIDTH(1), .CNT_WIDTH(16)) b1 ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_WIDTH(3))  b3 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(16)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  logic_unit_pipe #(.WIDTH(1), .CNT_WIDTH(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(3))  u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vectors for the 8-bit instance, with hand-computed expectations.
  logic [7:0] va [8];
  logic [7:0] vb [8];
  logic [2:0] vop[8];
  logic [7:0] ey [8];
  logic       ez [8];
  logic       ep [8];
  logic       ee [8];
  int         first_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [7:0] y,
                         input logic z, input logic p, input logic e);
    va[i] = a; vb[i] = b; vop[i] = op; ey[i] = y; ez[i] = z; ep[i] = p; ee[i] = e;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Streams n vectors into u8 with a handshaking source; holds out_ready low
  // for stall_len cycles starting when the first result appears. Entered and
  // left at posedge+1.
  task automatic stream8(input int n, input int stall_len, input string tag);
    int snd, rcv, stall_cnt;
    snd = 0; rcv = 0; stall_cnt = 0; first_cyc = -1;
    for (int c = 0; c < 80 && rcv < n; c++) begin
      b8.in_valid = (snd < n);
      if (snd < n) begin
        b8.A = va[snd]; b8.B = vb[snd]; b8.op = vop[snd];
      end
      if (b8.out_valid && rcv == 0 && stall_cnt < stall_len) begin
        b8.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        b8.out_ready = 1'b1;
      end
      #1;
      if (b8.out_valid && first_cyc < 0) first_cyc = c;
      if (!b8.out_ready) begin
        check({tag, "_stall_in_ready"}, 32'(b8.in_ready), 32'(0));
        check({tag, "_stall_Y"}, 32'(b8.Y), 32'(ey[0]));
      end
      if (b8.out_valid && b8.out_ready) begin
        check($sformatf("%s_Y%0d", tag, rcv), 32'(b8.Y), 32'(ey[rcv]));
        check($sformatf("%s_zero%0d", tag, rcv), 32'(b8.zero), 32'(ez[rcv]));
        check($sformatf("%s_par%0d", tag, rcv), 32'(b8.parity), 32'(ep[rcv]));
        check($sformatf("%s_err%0d", tag, rcv), 32'(b8.err), 32'(ee[rcv]));
        rcv++;
      end
      if (b8.in_valid && b8.in_ready) snd++;
      @(posedge clk); #1;
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b1;
    check({tag, "_beats"}, 32'(rcv), 32'(n));
  endtask

  initial begin
    logic [3:0] tt [7];
    logic       e1 [28];
    int         rcv;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    b8.in_valid = 0; b8.A = '0; b8.B = '0; b8.op = '0; b8.out_ready = 1;
    b1.in_valid = 0; b1.A = '0; b1.B = '0; b1.op = '0; b1.out_ready = 1;
    b3.in_valid = 0; b3.A = '0; b3.B = '0; b3.op = '0; b3.out_ready = 1;
    @(posedge clk); #1;

    // Reset state
    do_reset();
    #1;
    check("rst_out_valid", 32'(b8.out_valid), 32'(0));
    check("rst_Y",         32'(b8.Y), 32'(0));
    check("rst_zero",      32'(b8.zero), 32'(0));
    check("rst_parity",    32'(b8.parity), 32'(0));
    check("rst_err",       32'(b8.err), 32'(0));
    check("rst_op_count",  32'(b8.op_count), 32'(0));
    check("rst_in_ready",  32'(b8.in_ready), 32'(1));
    check("rst_u3_count",  32'(b3.op_count), 32'(0));
    @(posedge clk); #1;

    // Opcode sweep, A=F0 B=CC
    set_vec(0, 8'hF0, 8'hCC, 3'd0, 8'hC0, 0, 0, 0);
    set_vec(1, 8'hF0, 8'hCC, 3'd1, 8'hFC, 0, 0, 0);
    set_vec(2, 8'hF0, 8'hCC, 3'd2, 8'h0F, 0, 0, 0);
    set_vec(3, 8'hF0, 8'hCC, 3'd3, 8'h3C, 0, 0, 0);
    set_vec(4, 8'hF0, 8'hCC, 3'd4, 8'h3F, 0, 0, 0);
    set_vec(5, 8'hF0, 8'hCC, 3'd5, 8'h03, 0, 0, 0);
    set_vec(6, 8'hF0, 8'hCC, 3'd6, 8'hC3, 0, 0, 0);
    stream8(7, 0, "sweep");
    check("sweep_latency", 32'(first_cyc), 32'(2));
    check("sweep_op_count", 32'(b8.op_count), 32'(7));
    check("sweep_idle_valid", 32'(b8.out_valid), 32'(0));

    // Backpressure: 5 XOR beats, 4-cycle stall on the first result
    do_reset();
    @(posedge clk); #1;
    set_vec(0, 8'h11, 8'hF0, 3'd3, 8'hE1, 0, 0, 0);
    set_vec(1, 8'h22, 8'hF0, 3'd3, 8'hD2, 0, 0, 0);
    set_vec(2, 8'h33, 8'hF0, 3'd3, 8'hC3, 0, 0, 0);
    set_vec(3, 8'h44, 8'hF0, 3'd3, 8'hB4, 0, 0, 0);
    set_vec(4, 8'h55, 8'hF0, 3'd3, 8'hA5, 0, 0, 0);
    stream8(5, 4, "bp");
    check("bp_op_count", 32'(b8.op_count), 32'(5));

    // Flags and illegal opcode
    set_vec(0, 8'hAA, 8'h55, 3'd0, 8'h00, 1, 0, 0);
    set_vec(1, 8'hAA, 8'h55, 3'd3, 8'hFF, 0, 0, 0);
    set_vec(2, 8'h01, 8'h55, 3'd2, 8'hFE, 0, 1, 0);
    set_vec(3, 8'hAA, 8'h55, 3'd7, 8'h00, 1, 0, 1);
    stream8(4, 0, "flags");
    check("flags_op_count", 32'(b8.op_count), 32'(9));

    // Exhaustive 1-bit truth tables, bit index = {A,B}
    tt[0] = 4'b1000;  // AND
    tt[1] = 4'b1110;  // OR
    tt[2] = 4'b0011;  // NOT A
    tt[3] = 4'b0110;  // XOR
    tt[4] = 4'b0111;  // NAND
    tt[5] = 4'b0001;  // NOR
    tt[6] = 4'b1001;  // XNOR
    for (int k = 0; k < 28; k++) e1[k] = tt[k / 4][k % 4];
    rcv = 0;
    for (int c = 0; c < 40 && rcv < 28; c++) begin
      b1.in_valid = (c < 28);
      if (c < 28) begin
        b1.op = 3'(c / 4);
        b1.A  = 1'((c % 4) >> 1);
        b1.B  = 1'(c % 2);
      end
      #1;
      if (b1.out_valid) begin
        check($sformatf("bit_op%0d_ab%0d", rcv / 4, rcv % 4), 32'(b1.Y), 32'(e1[rcv]));
        rcv++;
      end
      @(posedge clk); #1;
    end
    b1.in_valid = 1'b0;
    check("bit_beats", 32'(rcv), 32'(28));
    check("bit_op_count", 32'(b1.op_count), 32'(28));

    // Counter wrap on 3-bit counter: 9 AND-with-FF beats
    rcv = 0;
    for (int c = 0; c < 20 && rcv < 9; c++) begin
      b3.in_valid = (c < 9);
      b3.A  = 8'(c);
      b3.B  = 8'hFF;
      b3.op = 3'd0;
      #1;
      if (b3.out_valid) begin
        if (rcv == 8) check("wrap_last_Y", 32'(b3.Y), 32'(8));
        rcv++;
      end
      @(posedge clk); #1;
    end
    b3.in_valid = 1'b0;
    check("wrap_beats", 32'(rcv), 32'(9));
    check("wrap_op_count", 32'(b3.op_count), 32'(1));

    // Reset mid-flight with two beats in the pipe
    b8.out_ready = 1'b1;
    b8.in_valid = 1'b1; b8.A = 8'h0F; b8.B = 8'h30; b8.op = 3'd1;
    @(posedge clk); #1;
    b8.A = 8'h0F; b8.B = 8'hF0; b8.op = 3'd0;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    #1;
    check("mid_pre_valid", 32'(b8.out_valid), 32'(1));
    check("mid_pre_Y", 32'(b8.Y), 32'(8'h3F));
    #1 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(b8.out_valid), 32'(0));
    check("mid_op_count", 32'(b8.op_count), 32'(0));
    check("mid_Y", 32'(b8.Y), 32'(0));
    check("mid_in_ready", 32'(b8.in_ready), 32'(1));
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      check($sformatf("mid_no_ghost%0d", c), 32'(b8.out_valid), 32'(0));
    end
    check("mid_final_count", 32'(b8.op_count), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
